// File: rtl/bt_em_pkg.sv
// Shared definitions for the Bluetooth exchange-memory arbiter.
//   EM_ADR_W / EM_DAT_W : word address and data widths of the exchange memory
//   EM_BE_W             : byte-enable width derived from the data width
//   em_state_t          : arbiter FSM states
//   em_grant_t          : which master owns the in-flight access
package bt_em_pkg;

  localparam int EM_ADR_W = 23;
  localparam int EM_DAT_W = 32;
  localparam int EM_BE_W  = EM_DAT_W / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } em_state_t;

  typedef enum logic {
    GNT_BREDR = 1'b0,
    GNT_PCM   = 1'b1
  } em_grant_t;

endpackage

// File: rtl/bt_em_arb.sv
// Two-master arbiter in front of the exchange memory (EM).
// Masters: BR/EDR baseband (bredr_*) and PCM DMA (pcm_dma_*). Each master
// holds req/we/adr/wdat until its single-cycle ack. PCM wins by default;
// BR/EDR wins once PCM has taken PCM_MAX_RUN consecutive grants while
// BR/EDR was waiting. An access that sees no em_ack for ACK_TIMEOUT WAIT
// cycles is aborted: em_timeout pulses and the master is acked with zero
// read data.
// Ports:
//   bsb_clk, bsb_rst          clock, asynchronous active-high reset
//   bredr_em_* / pcm_dma_*    master request side (req, we, adr, wdat in;
//                             rdat, ack out)
//   em_req/we/adr/wdat        registered request towards the memory
//   em_rdat, em_ack           memory response (em_ack is a 1-cycle pulse)
//   em_timeout                1-cycle pulse when an access is aborted
module bt_em_arb
  import bt_em_pkg::*;
#(
  parameter int PCM_MAX_RUN = 4,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                bsb_clk,
  input  logic                bsb_rst,
  input  logic                bredr_em_req,
  input  logic [EM_BE_W-1:0]  bredr_em_we,
  input  logic [EM_ADR_W-1:0] bredr_em_adr,
  input  logic [EM_DAT_W-1:0] bredr_em_wdat,
  output logic [EM_DAT_W-1:0] bredr_em_rdat,
  output logic                bredr_em_ack,
  input  logic                pcm_dma_req,
  input  logic [EM_BE_W-1:0]  pcm_dma_we,
  input  logic [EM_ADR_W-1:0] pcm_dma_adr,
  input  logic [EM_DAT_W-1:0] pcm_dma_wdat,
  output logic [EM_DAT_W-1:0] pcm_dma_rdat,
  output logic                pcm_dma_ack,
  output logic                em_req,
  output logic [EM_BE_W-1:0]  em_we,
  output logic [EM_ADR_W-1:0] em_adr,
  output logic [EM_DAT_W-1:0] em_wdat,
  input  logic [EM_DAT_W-1:0] em_rdat,
  input  logic                em_ack,
  output logic                em_timeout
);

  localparam int RUN_W = (PCM_MAX_RUN < 1) ? 1 : $clog2(PCM_MAX_RUN + 1);
  localparam int TMO_W = (ACK_TIMEOUT < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [RUN_W-1:0] RUN_MAX   = RUN_W'(PCM_MAX_RUN);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(ACK_TIMEOUT);

  em_state_t           state_reg, state_next;
  em_grant_t           grant_reg, grant_next;
  logic [RUN_W-1:0]    run_cnt_reg, run_cnt_next;
  logic [TMO_W-1:0]    wait_cnt_reg, wait_cnt_next;
  logic                em_req_reg, em_req_next;
  logic [EM_BE_W-1:0]  em_we_reg, em_we_next;
  logic [EM_ADR_W-1:0] em_adr_reg, em_adr_next;
  logic [EM_DAT_W-1:0] em_wdat_reg, em_wdat_next;

  logic bredr_wins;
  logic ack_hit;
  logic tmo_hit;

  // BR/EDR only wins a contested slot once PCM has used up its run.
  assign bredr_wins = bredr_em_req && (!pcm_dma_req || (run_cnt_reg == RUN_MAX));

  // Completion is only recognised in WAIT; a memory ack in the same cycle as
  // the timeout limit still counts as a real completion.
  assign ack_hit = (state_reg == WAIT) && em_ack;
  assign tmo_hit = (state_reg == WAIT) && !em_ack && (wait_cnt_reg == TMO_LIMIT);

  always_comb begin
    state_next    = state_reg;
    grant_next    = grant_reg;
    run_cnt_next  = run_cnt_reg;
    wait_cnt_next = wait_cnt_reg;
    em_req_next   = em_req_reg;
    em_we_next    = em_we_reg;
    em_adr_next   = em_adr_reg;
    em_wdat_next  = em_wdat_reg;

    case (state_reg)
      IDLE: begin
        if (!bredr_em_req) begin
          run_cnt_next = '0;
        end
        if (bredr_em_req || pcm_dma_req) begin
          state_next  = GRANT;
          em_req_next = 1'b1;
          if (bredr_wins) begin
            grant_next   = GNT_BREDR;
            em_we_next   = bredr_em_we;
            em_adr_next  = bredr_em_adr;
            em_wdat_next = bredr_em_wdat;
            run_cnt_next = '0;
          end else begin
            grant_next   = GNT_PCM;
            em_we_next   = pcm_dma_we;
            em_adr_next  = pcm_dma_adr;
            em_wdat_next = pcm_dma_wdat;
            // Only grants that made BR/EDR wait count towards the run.
            if (bredr_em_req && (run_cnt_reg != RUN_MAX)) begin
              run_cnt_next = run_cnt_reg + 1'b1;
            end
          end
        end
      end
      GRANT: begin
        state_next    = WAIT;
        wait_cnt_next = '0;
      end
      WAIT: begin
        if (ack_hit || tmo_hit) begin
          state_next   = DONE;
          em_req_next  = 1'b0;
          em_we_next   = '0;
          em_adr_next  = '0;
          em_wdat_next = '0;
        end else begin
          wait_cnt_next = wait_cnt_reg + 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge bsb_clk or posedge bsb_rst) begin
    if (bsb_rst) begin
      state_reg    <= IDLE;
      grant_reg    <= GNT_BREDR;
      run_cnt_reg  <= '0;
      wait_cnt_reg <= '0;
      em_req_reg   <= 1'b0;
      em_we_reg    <= '0;
      em_adr_reg   <= '0;
      em_wdat_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      grant_reg    <= grant_next;
      run_cnt_reg  <= run_cnt_next;
      wait_cnt_reg <= wait_cnt_next;
      em_req_reg   <= em_req_next;
      em_we_reg    <= em_we_next;
      em_adr_reg   <= em_adr_next;
      em_wdat_reg  <= em_wdat_next;
    end
  end

  assign em_req     = em_req_reg;
  assign em_we      = em_we_reg;
  assign em_adr     = em_adr_reg;
  assign em_wdat    = em_wdat_reg;
  assign em_timeout = tmo_hit;

  // Routing follows the latched grant so a master that drops req early
  // still receives its completion. Read data passes straight through from
  // memory in the ack cycle; an aborted access returns zero.
  assign bredr_em_ack  = (ack_hit || tmo_hit) && (grant_reg == GNT_BREDR);
  assign pcm_dma_ack   = (ack_hit || tmo_hit) && (grant_reg == GNT_PCM);
  assign bredr_em_rdat = (ack_hit && (grant_reg == GNT_BREDR)) ? em_rdat : '0;
  assign pcm_dma_rdat  = (ack_hit && (grant_reg == GNT_PCM))   ? em_rdat : '0;

endmodule

// File: doc/bt_em_arb.md
BT_EM_ARB -- requirements
Module: bt_em_arb

Interface
REQ-001 Parameter PCM_MAX_RUN, default 4: maximum consecutive PCM grants while BR/EDR is waiting.
REQ-002 Parameter ACK_TIMEOUT, default 255: number of bsb_clk cycles to wait for em_ack before aborting.
REQ-003 Ports (name, direction, width, meaning); one clock, reset asynchronous active-high:
- bsb_clk  in  1  baseband clock
- bsb_rst  in  1  async active-high reset
- bredr_em_req  in  1  BR/EDR master request, level
- bredr_em_we  in  4  BR/EDR byte write enables; 0 = read
- bredr_em_adr  in  23  BR/EDR word address
- bredr_em_wdat  in  32  BR/EDR write data
- bredr_em_rdat  out  32  BR/EDR read data
- bredr_em_ack  out  1  BR/EDR completion pulse
- pcm_dma_req/we/adr/wdat  in  1/4/23/32  PCM DMA master, same meaning as the BR/EDR inputs
- pcm_dma_rdat  out  32  PCM DMA read data
- pcm_dma_ack  out  1  PCM DMA completion pulse
- em_req  out  1  request to external memory
- em_we  out  4  byte enables to external memory
- em_adr  out  23  address to external memory
- em_wdat  out  32  write data to external memory
- em_rdat  in  32  read data from external memory
- em_ack  in  1  external memory completion, 1-cycle pulse
- em_timeout  out  1  1-cycle pulse on transaction abort

Function
REQ-004 Master protocol: req, we, adr and wdat are held stable until ack; ack is a single-cycle pulse; the master drops req in the cycle after ack.
REQ-005 FSM states: IDLE, GRANT, WAIT, DONE.
REQ-006 IDLE: when any req is high, the winner is selected and latched; next state is GRANT.
REQ-007 GRANT: em_req, em_we, em_adr and em_wdat are driven from registers copied from the winner; next state is WAIT. em_req is first high one cycle after the winning req is sampled.
REQ-008 WAIT: em_req stays high until em_ack. On em_ack:
- the granted master's ack is high in the same cycle;
- its rdat equals em_rdat in the same cycle, combinational pass-through;
- em_req drops on the next edge;
- next state is DONE.
REQ-009 DONE: one bubble cycle with no arbitration; next state is IDLE. Back-to-back grants are therefore spaced 4 cycles minimum.
REQ-010 Priority: PCM wins by default. BR/EDR wins when both request and the PCM run counter equals PCM_MAX_RUN.
REQ-011 PCM run counter:
- increments on each PCM grant made while bredr_em_req is high;
- clears on any BR/EDR grant, or when bredr_em_req is low in IDLE;
- saturates at PCM_MAX_RUN.
REQ-012 The non-granted master's ack is always 0 and its rdat is always 0.
REQ-013 Timeout: the WAIT-cycle counter reaches ACK_TIMEOUT without em_ack ->
- em_req drops;
- em_timeout pulses 1 cycle;
- the granted master receives ack with rdat = 32'h0;
- next state is DONE.
REQ-014 em_ack outside WAIT is ignored and generates no master ack.
REQ-015 A requester dropping req before its ack is a protocol violation. The in-flight transaction still completes from the latched copy.
REQ-016 Ack routing uses the latched grant, not live req levels.

Reset
REQ-017 While bsb_rst is high, all of the following are 0 asynchronously, regardless of in-flight transactions:
- em_req, em_we, em_adr, em_wdat;
- both master acks and rdats;
- em_timeout;
- the run counter and the timeout counter;
- state = IDLE.
REQ-018 After a mid-transaction reset, no master ack is generated for the aborted access; masters re-request.

Structure
REQ-019 Shared package bt_em_pkg holds:
- EM_ADR_W = 23 and EM_DAT_W = 32;
- typedef em_state_t {IDLE, GRANT, WAIT, DONE};
- typedef em_grant_t {GNT_BREDR, GNT_PCM}.
REQ-020 Single module; no sub-module. The run counter and the timeout counter are inline.

Verification
REQ-021 Single BR/EDR read, adr 23'h00_1234, em_ack with em_rdat 32'hDEAD_BEEF 3 cycles after em_req -> bredr_em_ack and bredr_em_rdat = 32'hDEAD_BEEF in the same cycle; pcm_dma_ack stays 0.
REQ-022 Both masters request at the same cycle, PCM held continuously -> grant order PCM×4, BR/EDR, then PCM resumes.
REQ-023 PCM write, we = 4'b0011, wdat 32'h0000_A5A5 -> em_we = 4'b0011 and em_wdat = 32'h0000_A5A5 held until em_ack.
REQ-024 em_ack never returned, ACK_TIMEOUT = 8 -> em_timeout pulses after 8 WAIT cycles; master ack pulses with rdat = 0; FSM returns to IDLE.
REQ-025 bsb_rst asserted in WAIT -> em_req = 0 immediately, no ack pulse; a new request after reset is served normally.
REQ-026 Stray em_ack in IDLE -> no master ack; state unchanged.
